// File: rtl/als_sample_scheduler.sv
// als_sample_scheduler: periodic request/average/hysteresis sequencer for a
// single-shot SPI ambient-light reader (start/done handshake).
// Optional macro ALS_SCHED_MINMAX_EN adds win_min/win_max window outputs.
module als_sample_scheduler #(
  parameter int PERIOD   = 100000,
  parameter int AVG_LOG2 = 3,
  parameter int TIMEOUT  = 4096,
  parameter int HYST     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] threshold,
  input  logic       err_clr,
  output logic       start,
  input  logic       done,
  input  logic [7:0] rd_data,
  output logic [7:0] avg,
  output logic       avg_valid,
  output logic       light,
  output logic       timeout_err
`ifdef ALS_SCHED_MINMAX_EN
  ,
  output logic [7:0] win_min,
  output logic [7:0] win_max
`endif
);

  localparam int PCNT_W = $clog2(PERIOD);
  localparam int TCNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int SMP_W  = AVG_LOG2 + 1;
  localparam int ACC_W  = 8 + AVG_LOG2;

  localparam logic [PCNT_W-1:0] PCNT_END = PCNT_W'(PERIOD - 2);
  // The counter is compared before its increment, so the hit fires on the
  // edge where it would reach TIMEOUT-1.
  localparam logic [TCNT_W-1:0] TCNT_HIT = TCNT_W'(TIMEOUT - 2);
  localparam logic [SMP_W-1:0]  SMP_LAST = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [7:0]        HYST8    = 8'(HYST);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_START, S_BUSY, S_ACC} state_t;

  state_t             state_reg, state_next;
  logic [PCNT_W-1:0]  period_cnt_reg, period_cnt_next;
  logic [TCNT_W-1:0]  tmo_cnt_reg, tmo_cnt_next;
  logic [SMP_W-1:0]   smp_cnt_reg, smp_cnt_next;
  logic [ACC_W-1:0]   acc_reg, acc_next;
  logic [7:0]         sample_reg, sample_next;
  logic               start_reg, start_next;
  logic [7:0]         avg_reg, avg_next;
  logic               avg_valid_reg, avg_valid_next;
  logic               light_reg, light_next;
  logic               err_reg, err_next;
`ifdef ALS_SCHED_MINMAX_EN
  logic [7:0]         run_min_reg, run_min_next, run_max_reg, run_max_next;
  logic [7:0]         win_min_reg, win_min_next, win_max_reg, win_max_next;
  logic [7:0]         smp_min, smp_max;
`endif

  logic               period_end, tmo_hit, win_last;
  logic [ACC_W-1:0]   sum;
  logic [7:0]         new_avg;
  logic [8:0]         hi_sum;
  logic [7:0]         hi_lvl, lo_lvl;

  assign period_end = (period_cnt_reg == PCNT_END);
  assign tmo_hit    = (tmo_cnt_reg == TCNT_HIT);
  assign win_last   = (smp_cnt_reg == SMP_LAST);
  assign sum        = acc_reg + ACC_W'(sample_reg);
  assign new_avg    = sum[AVG_LOG2 +: 8];
  // Hysteresis levels, clamped to the 8-bit range
  assign hi_sum     = {1'b0, threshold} + {1'b0, HYST8};
  assign hi_lvl     = hi_sum[8] ? 8'hFF : hi_sum[7:0];
  assign lo_lvl     = (threshold < HYST8) ? 8'h00 : (threshold - HYST8);
`ifdef ALS_SCHED_MINMAX_EN
  assign smp_min    = (sample_reg < run_min_reg) ? sample_reg : run_min_reg;
  assign smp_max    = (sample_reg > run_max_reg) ? sample_reg : run_max_reg;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; a late reader jumps straight from S_ACC to S_START
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (enable) state_next = S_WAIT;
      S_WAIT:  if (!enable) state_next = S_IDLE;
               else if (period_end) state_next = S_START;
      S_START: state_next = enable ? S_BUSY : S_IDLE;
      S_BUSY:  if (done || tmo_hit)
                 state_next = !enable ? S_IDLE : (done ? S_ACC : S_WAIT);
      S_ACC:   if (!enable) state_next = S_IDLE;
               else if (period_end) state_next = S_START;
               else state_next = S_WAIT;
      default: state_next = S_IDLE;
    endcase
  end

  // Output / datapath next values (all outputs are registered)
  always_comb begin
    period_cnt_next = period_cnt_reg;
    tmo_cnt_next    = tmo_cnt_reg;
    smp_cnt_next    = smp_cnt_reg;
    acc_next        = acc_reg;
    sample_next     = sample_reg;
    avg_next        = avg_reg;
    light_next      = light_reg;
    err_next        = err_clr ? 1'b0 : err_reg;
    avg_valid_next  = 1'b0;
    start_next      = (state_next == S_START);
`ifdef ALS_SCHED_MINMAX_EN
    run_min_next    = run_min_reg;
    run_max_next    = run_max_reg;
    win_min_next    = win_min_reg;
    win_max_next    = win_max_reg;
`endif
    // Period counter saturates at its terminal value so a slow reader never wraps it
    if (!period_end) period_cnt_next = period_cnt_reg + PCNT_W'(1);
    case (state_reg)
      S_IDLE: begin
        period_cnt_next = '0;
        smp_cnt_next    = '0;
        acc_next        = '0;
`ifdef ALS_SCHED_MINMAX_EN
        run_min_next    = 8'hFF;
        run_max_next    = 8'h00;
`endif
      end
      S_START: begin
        period_cnt_next = '0;
        tmo_cnt_next    = '0;
      end
      S_BUSY: begin
        tmo_cnt_next = tmo_cnt_reg + TCNT_W'(1);
        if (done)         sample_next = rd_data;
        else if (tmo_hit) err_next    = 1'b1;
      end
      S_ACC: begin
        if (!enable) begin
          smp_cnt_next = '0;
          acc_next     = '0;
        end else if (win_last) begin
          smp_cnt_next   = '0;
          acc_next       = '0;
          avg_next       = new_avg;
          avg_valid_next = 1'b1;
          if (new_avg >= hi_lvl)     light_next = 1'b1;
          else if (new_avg < lo_lvl) light_next = 1'b0;
`ifdef ALS_SCHED_MINMAX_EN
          win_min_next = smp_min;
          win_max_next = smp_max;
          run_min_next = 8'hFF;
          run_max_next = 8'h00;
`endif
        end else begin
          smp_cnt_next = smp_cnt_reg + SMP_W'(1);
          acc_next     = sum;
`ifdef ALS_SCHED_MINMAX_EN
          run_min_next = smp_min;
          run_max_next = smp_max;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_cnt_reg <= '0;
      tmo_cnt_reg    <= '0;
      smp_cnt_reg    <= '0;
      acc_reg        <= '0;
      sample_reg     <= '0;
      start_reg      <= 1'b0;
      avg_reg        <= 8'h00;
      avg_valid_reg  <= 1'b0;
      light_reg      <= 1'b0;
      err_reg        <= 1'b0;
`ifdef ALS_SCHED_MINMAX_EN
      run_min_reg    <= 8'hFF;
      run_max_reg    <= 8'h00;
      win_min_reg    <= 8'hFF;
      win_max_reg    <= 8'h00;
`endif
    end else begin
      period_cnt_reg <= period_cnt_next;
      tmo_cnt_reg    <= tmo_cnt_next;
      smp_cnt_reg    <= smp_cnt_next;
      acc_reg        <= acc_next;
      sample_reg     <= sample_next;
      start_reg      <= start_next;
      avg_reg        <= avg_next;
      avg_valid_reg  <= avg_valid_next;
      light_reg      <= light_next;
      err_reg        <= err_next;
`ifdef ALS_SCHED_MINMAX_EN
      run_min_reg    <= run_min_next;
      run_max_reg    <= run_max_next;
      win_min_reg    <= win_min_next;
      win_max_reg    <= win_max_next;
`endif
    end
  end

  assign start       = start_reg;
  assign avg         = avg_reg;
  assign avg_valid   = avg_valid_reg;
  assign light       = light_reg;
  assign timeout_err = err_reg;
`ifdef ALS_SCHED_MINMAX_EN
  assign win_min     = win_min_reg;
  assign win_max     = win_max_reg;
`endif

endmodule
